// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM request queue: request header layout,
// burst-code constants and the beat count derived from a burst code.
package sdram_pkg;

  localparam logic [2:0] BURST_1 = 3'd0;
  localparam logic [2:0] BURST_2 = 3'd1;
  localparam logic [2:0] BURST_4 = 3'd2;
  localparam logic [2:0] BURST_8 = 3'd3;

  localparam int BEATS_W = 4;

  // Fixed-width request fields. The address and write data are parameter-sized,
  // so they travel alongside this header in the FIFO word.
  typedef struct packed {
    logic       write;
    logic       burst;
    logic [2:0] burst_len;
    logic [1:0] byteenable;
  } req_hdr_t;

  // Codes 4-7 are illegal and are treated as the 8-beat code.
  function automatic logic [BEATS_W-1:0] beats_from_code(input logic       burst,
                                                         input logic [2:0] code);
    logic [1:0] c;
    c = code[2] ? BURST_8[1:0] : code[1:0];
    if (!burst) return BEATS_W'(1);
    return BEATS_W'(1) << c;
  endfunction

endpackage

// File: rtl/sdram_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; pointers carry one extra wrap bit
// so that full and empty are distinguishable.
module sdram_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: only the pointers are reset; stale storage is never visible because
  // empty is decided by the pointers alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sdram_req_queue.sv
// Host-side request queue for an SDRAM controller: in-order request FIFO,
// read-beat credit limiting, and a one-cycle registered read-data return path.
module sdram_req_queue
  import sdram_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 24,
  parameter int DEPTH  = 4,
  parameter int MAX_RD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_write,
  input  logic [AW-1:0] host_addr,
  input  logic          host_burst,
  input  logic [2:0]    host_burst_len,
  input  logic [DW-1:0] host_wdata,
  input  logic [1:0]    host_byteenable,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          bus_read,
  output logic          bus_write,
  output logic [AW-1:0] bus_addr,
  output logic          bus_burst,
  output logic [2:0]    bus_burst_len,
  output logic [DW-1:0] bus_wdata,
  output logic [1:0]    bus_byteenable,
  input  logic          bus_ready,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata,
  output logic          err_underflow
);

  localparam int HW = $bits(req_hdr_t);
  localparam int FW = AW + DW + HW;
  localparam int RW = $clog2(MAX_RD + 1);

  req_hdr_t            push_hdr, head_hdr;
  logic [FW-1:0]       push_word, head_word;
  logic                fifo_full, fifo_empty, push, pop;
  logic [BEATS_W-1:0]  head_beats;
  logic                issue_rd, underflow;

  logic [RW-1:0]       rd_out_q, rd_out_d;
  logic                ready_en_q;
  logic                host_rvalid_q;
  logic [DW-1:0]       host_rdata_q;
  logic                err_q;

  // Writes are always single-beat, so burst fields are squashed on entry.
  always_comb begin
    push_hdr            = '0;
    push_hdr.write      = host_write;
    push_hdr.burst      = host_write ? 1'b0 : host_burst;
    push_hdr.burst_len  = host_write ? 3'd0 : host_burst_len;
    push_hdr.byteenable = host_byteenable;
  end

  assign push_word  = {host_addr, host_wdata, push_hdr};
  assign host_ready = ready_en_q && !fifo_full;
  assign push       = host_valid && host_ready;

  sdram_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (pop),
    .rdata_o (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_hdr       = req_hdr_t'(head_word[HW-1:0]);
  assign bus_wdata      = head_word[HW +: DW];
  assign bus_addr       = head_word[HW+DW +: AW];
  assign bus_burst      = head_hdr.burst;
  assign bus_burst_len  = head_hdr.burst_len;
  assign bus_byteenable = head_hdr.byteenable;
  assign head_beats     = beats_from_code(head_hdr.burst, head_hdr.burst_len);

  // A read is only offered once its full beat count fits in the credit window.
  assign bus_write = !fifo_empty && head_hdr.write;
  assign bus_read  = !fifo_empty && !head_hdr.write &&
                     ((int'(rd_out_q) + int'(head_beats)) <= MAX_RD);
  assign pop       = (bus_read || bus_write) && bus_ready;
  assign issue_rd  = bus_read && bus_ready;
  assign underflow = bus_rvalid && (rd_out_q == '0);

  always_comb begin
    rd_out_d = rd_out_q;
    if (issue_rd)                rd_out_d = rd_out_d + RW'(head_beats);
    if (bus_rvalid && !underflow) rd_out_d = rd_out_d - RW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_out_q      <= '0;
      ready_en_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      rd_out_q      <= rd_out_d;
      ready_en_q    <= 1'b1;
      host_rvalid_q <= bus_rvalid;
      host_rdata_q  <= bus_rdata;
      if (underflow) err_q <= 1'b1;
    end
  end

  assign host_rvalid   = host_rvalid_q;
  assign host_rdata    = host_rdata_q;
  assign err_underflow = err_q;

endmodule
